// File: rtl/access_pkg.sv
// Shared types and width rules for the game-access controller.
package access_pkg;

  typedef enum logic [2:0] {
    ST_ENTER      = 3'd0,
    ST_VERIFY     = 3'd1,
    ST_LOCKOUT    = 3'd2,
    ST_RECONFIG   = 3'd3,
    ST_WAIT_START = 3'd4,
    ST_PLAY       = 3'd5,
    ST_OVER       = 3'd6
  } state_e;

  function automatic int unsigned fail_w_f(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

  function automatic int unsigned lock_w_f(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

  // Digit 0 is the most-significant slice of the packed code.
  function automatic logic [63:0] digit_at(input logic [63:0] code, input int unsigned i,
                                           input int unsigned code_len, input int unsigned digit_w);
    logic [63:0] mask;
    mask = (64'd1 << digit_w) - 64'd1;
    return (code >> ((code_len - 1 - i) * digit_w)) & mask;
  endfunction

endpackage

// File: rtl/access_ctrl_n_if.sv
// Passcode, play-control and status signals of the access controller.
interface access_ctrl_n_if #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned N_PLAYERS = 1,
  parameter int unsigned FAIL_W    = 2,
  parameter int unsigned WIN_W     = 7
);
  logic [DIGIT_W-1:0]   pass_digit;
  logic                 pass_enter;
  logic [N_PLAYERS-1:0] load_in;
  logic                 rng_button;
  logic                 timeout;
  logic                 win;
  logic [N_PLAYERS-1:0] load_out;
  logic                 rng_gen;
  logic                 timer_enable;
  logic                 reconfig;
  logic                 logout_led;
  logic                 login_led;
  logic                 gameover;
  logic                 locked;
  logic [FAIL_W-1:0]    fail_count;
  logic [WIN_W-1:0]     win_count;

  modport slave (
    input  pass_digit, pass_enter, load_in, rng_button, timeout, win,
    output load_out, rng_gen, timer_enable, reconfig, logout_led, login_led,
           gameover, locked, fail_count, win_count
  );

  modport master (
    output pass_digit, pass_enter, load_in, rng_button, timeout, win,
    input  load_out, rng_gen, timer_enable, reconfig, logout_led, login_led,
           gameover, locked, fail_count, win_count
  );
endinterface

// File: rtl/access_ctrl_n_lockout_timer.sv
// Lockout countdown: load arms it, done is high in the LOCK_CYCLES-th armed cycle.
// Loading while armed restarts the count.
module lockout_timer import access_pkg::*; #(
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o
);
  localparam int unsigned CNT_W = lock_w_f(LOCK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  assign done_o = active_q && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = CNT_W'(LOCK_CYCLES - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/access_ctrl_n.sv
// Passcode login with lockout, then reconfig/start/play/over sequencing with win counting.
// Outputs are registered from the next state: one cycle after the causing input.
module access_ctrl_n import access_pkg::*; #(
  parameter int unsigned                 CODE_LEN    = 4,
  parameter int unsigned                 DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] PASSCODE    = 16'h9861,
  parameter int unsigned                 MAX_TRIES   = 3,
  parameter int unsigned                 LOCK_CYCLES = 1000,
  parameter int unsigned                 N_PLAYERS   = 1,
  parameter int unsigned                 WIN_MAX     = 99,
  parameter int unsigned                 WIN_W       = 7
) (
  input logic           clk,
  input logic           rst,
  access_ctrl_n_if.slave acc_if
);
  localparam int unsigned FAIL_W = fail_w_f(MAX_TRIES);
  localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [63:0] CODE64 = 64'(PASSCODE);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 match_q, match_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic                 prev_win_q;
  logic                 rng_gen_q, rng_gen_d;
  logic [N_PLAYERS-1:0] load_out_q, load_out_d;
  logic                 timer_en_q, timer_en_d;
  logic                 reconfig_q, reconfig_d;
  logic                 login_q, login_d;
  logic                 gameover_q, gameover_d;
  logic                 locked_q, locked_d;
  logic                 lock_load, lock_done;
  logic [63:0]          exp_digit;

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lockout_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (lock_load),
    .done_o (lock_done)
  );

  always_comb begin
    exp_digit = digit_at(CODE64, 32'(idx_q), CODE_LEN, DIGIT_W);
    state_d   = state_q;
    idx_d     = idx_q;
    match_d   = match_q;
    fail_d    = fail_q;
    win_d     = win_q;
    lock_load = 1'b0;
    case (state_q)
      ST_ENTER: if (acc_if.pass_enter) begin
        match_d = match_q & (64'(acc_if.pass_digit) == exp_digit);
        if (idx_q == IDX_W'(CODE_LEN - 1)) begin
          idx_d   = '0;
          state_d = ST_VERIFY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_VERIFY: begin
        idx_d   = '0;
        match_d = 1'b1;
        if (match_q) begin
          fail_d  = '0;
          state_d = ST_RECONFIG;
        end else begin
          fail_d = fail_q + 1'b1;
          if (fail_d == FAIL_W'(MAX_TRIES)) begin
            lock_load = 1'b1;
            state_d   = ST_LOCKOUT;
          end else begin
            state_d = ST_ENTER;
          end
        end
      end
      ST_LOCKOUT: if (lock_done) begin
        fail_d  = '0;
        state_d = ST_ENTER;
      end
      ST_RECONFIG: begin
        win_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: if (acc_if.pass_enter) state_d = ST_PLAY;
      ST_PLAY: begin
        if (acc_if.win && !prev_win_q && (win_q < WIN_W'(WIN_MAX))) win_d = win_q + 1'b1;
        if (acc_if.timeout) state_d = ST_OVER;
      end
      ST_OVER: if (acc_if.pass_enter) state_d = ST_RECONFIG;
      default: begin
        state_d = ST_ENTER;
        idx_d   = '0;
        match_d = 1'b1;
        fail_d  = '0;
        win_d   = '0;
      end
    endcase

    // Registered outputs are a function of where we are going next.
    rng_gen_d  = 1'b1;
    load_out_d = '0;
    timer_en_d = 1'b0;
    reconfig_d = 1'b0;
    login_d    = 1'b0;
    gameover_d = 1'b0;
    locked_d   = 1'b0;
    case (state_d)
      ST_LOCKOUT:    locked_d = 1'b1;
      ST_RECONFIG:   begin reconfig_d = 1'b1; login_d = 1'b1; end
      ST_WAIT_START: begin login_d = 1'b1; rng_gen_d = acc_if.rng_button; end
      ST_PLAY: begin
        login_d    = 1'b1;
        rng_gen_d  = acc_if.rng_button;
        load_out_d = acc_if.load_in;
        timer_en_d = 1'b1;
      end
      ST_OVER:       begin login_d = 1'b1; gameover_d = 1'b1; end
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_ENTER;
      idx_q      <= '0;
      match_q    <= 1'b1;
      fail_q     <= '0;
      win_q      <= '0;
      prev_win_q <= 1'b0;
      rng_gen_q  <= 1'b1;
      load_out_q <= '0;
      timer_en_q <= 1'b0;
      reconfig_q <= 1'b0;
      login_q    <= 1'b0;
      gameover_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      win_q      <= win_d;
      prev_win_q <= acc_if.win;
      rng_gen_q  <= rng_gen_d;
      load_out_q <= load_out_d;
      timer_en_q <= timer_en_d;
      reconfig_q <= reconfig_d;
      login_q    <= login_d;
      gameover_q <= gameover_d;
      locked_q   <= locked_d;
    end
  end

  assign acc_if.rng_gen      = rng_gen_q;
  assign acc_if.load_out     = load_out_q;
  assign acc_if.timer_enable = timer_en_q;
  assign acc_if.reconfig     = reconfig_q;
  assign acc_if.login_led    = login_q;
  assign acc_if.logout_led   = ~login_q;
  assign acc_if.gameover     = gameover_q;
  assign acc_if.locked       = locked_q;
  assign acc_if.fail_count   = fail_q;
  assign acc_if.win_count    = win_q;
endmodule

// File: tb/tb_access_ctrl_n.sv
// Randomized scenario bench for access_ctrl_n with a default and a wide-code instance.
module tb_access_ctrl_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  access_ctrl_n_if #(.DIGIT_W(4), .N_PLAYERS(1), .FAIL_W(2), .WIN_W(7)) bus ();
  access_ctrl_n_if #(.DIGIT_W(8), .N_PLAYERS(3), .FAIL_W(2), .WIN_W(7)) bus2 ();

  access_ctrl_n dut (.clk(clk), .rst(rst), .acc_if(bus));
  access_ctrl_n #(.CODE_LEN(6), .DIGIT_W(8), .PASSCODE(48'h0102030405FF), .N_PLAYERS(3))
    dut2 (.clk(clk), .rst(rst), .acc_if(bus2));

  localparam logic [15:0] CODE  = 16'h9861;
  localparam logic [47:0] WCODE = 48'h0102030405FF;
  localparam logic [16:0] RST_VEC = {1'b1, 1'b1, 5'b0, 1'b0, 2'd0, 7'd0};

  int errors = 0;
  int checks = 0;

  function automatic logic [16:0] out_vec();
    return {bus.rng_gen, bus.logout_led, bus.login_led, bus.gameover, bus.locked,
            bus.timer_enable, bus.reconfig, bus.load_out, bus.fail_count, bus.win_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.pass_digit = d;
    bus.pass_enter = 1'b1;
    tick();
    bus.pass_enter = 1'b0;
  endtask

  task automatic press2(input logic [7:0] d);
    bus2.pass_digit = d;
    bus2.pass_enter = 1'b1;
    tick();
    bus2.pass_enter = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      press(c[15-4*i -: 4]);
    end
  endtask

  task automatic login();
    enter_code(CODE);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.rng_gen !== 1'b1) begin errors++; $display("FAIL reset rng_gen: got %b want 1", bus.rng_gen); end
    checks++; if (bus.logout_led !== 1'b1) begin errors++; $display("FAIL reset logout_led: got %b want 1", bus.logout_led); end
    checks++; if (bus.login_led !== 1'b0) begin errors++; $display("FAIL reset login_led: got %b want 0", bus.login_led); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset locked: got %b want 0", bus.locked); end
    checks++; if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL reset fail_count: got %0d want 0", bus.fail_count); end
    checks++; if (bus.win_count !== 7'd0) begin errors++; $display("FAIL reset win_count: got %0d want 0", bus.win_count); end
    checks++; if (out_vec() !== RST_VEC) begin errors++; $display("FAIL reset vector: got %h want %h", out_vec(), RST_VEC); end
    checks++; if (bus2.rng_gen !== 1'b1 || bus2.load_out !== 3'd0 || bus2.logout_led !== 1'b1) begin
      errors++; $display("FAIL reset wide: got rng=%b load=%b logout=%b want 1 000 1", bus2.rng_gen, bus2.load_out, bus2.logout_led);
    end
    rst = 1'b1;
  endtask

  task automatic test_login();
    do_reset();
    enter_code(CODE);
    checks++; if (bus.reconfig !== 1'b0) begin errors++; $display("FAIL login early reconfig: got %b want 0", bus.reconfig); end
    tick();
    checks++; if (bus.reconfig !== 1'b1) begin errors++; $display("FAIL login reconfig latency: got %b want 1", bus.reconfig); end
    checks++; if (bus.login_led !== 1'b1 || bus.logout_led !== 1'b0) begin
      errors++; $display("FAIL login leds: got login=%b logout=%b want 1 0", bus.login_led, bus.logout_led);
    end
    checks++; if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL login fail_count: got %0d want 0", bus.fail_count); end
    tick();
    checks++; if (bus.reconfig !== 1'b0 || bus.win_count !== 7'd0) begin
      errors++; $display("FAIL login wait_start: got reconfig=%b win=%0d want 0 0", bus.reconfig, bus.win_count);
    end
  endtask

  task automatic test_random_codes();
    for (int t = 0; t < 5; t++) begin
      int nw;
      do_reset();
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) begin
        logic [15:0] c;
        c = 16'($urandom);
        if (c == CODE) c = c ^ 16'h0001;
        enter_code(c);
        tick();
        checks++; if (bus.fail_count !== 2'(k + 1) || bus.locked !== 1'b0 || bus.reconfig !== 1'b0) begin
          errors++; $display("FAIL random wrong code %h: got fail=%0d locked=%b reconfig=%b want %0d 0 0",
                              c, bus.fail_count, bus.locked, bus.reconfig, k + 1);
        end
      end
      enter_code(CODE);
      tick();
      checks++; if (bus.reconfig !== 1'b1 || bus.fail_count !== 2'd0) begin
        errors++; $display("FAIL random login after %0d fails: got reconfig=%b fail=%0d want 1 0", nw, bus.reconfig, bus.fail_count);
      end
    end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      enter_code(16'h9862);
      tick();
      checks++; if (bus.fail_count !== 2'(k)) begin
        errors++; $display("FAIL lockout fail step: got %0d want %0d", bus.fail_count, k);
      end
    end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lockout assert: got %b want 1", bus.locked); end
    n = 0;
    while (bus.locked === 1'b1 && n < 2000) begin
      bus.pass_digit = 4'($urandom);
      bus.pass_enter = 1'($urandom);
      tick();
      n++;
      if (n == 500) begin
        checks++; if (bus.fail_count !== 2'd3 || bus.reconfig !== 1'b0) begin
          errors++; $display("FAIL lockout mid: got fail=%0d reconfig=%b want 3 0", bus.fail_count, bus.reconfig);
        end
      end
    end
    bus.pass_enter = 1'b0;
    checks++; if (n != 1000) begin errors++; $display("FAIL lockout duration: got %0d want 1000", n); end
    checks++; if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL lockout end fail_count: got %0d want 0", bus.fail_count); end
    enter_code(CODE);
    tick();
    checks++; if (bus.reconfig !== 1'b1) begin errors++; $display("FAIL lockout relogin: got %b want 1", bus.reconfig); end
  endtask

  task automatic test_play();
    int cnt;
    logic l, r;
    do_reset();
    login();
    r = 1'($urandom);
    bus.rng_button = r;
    tick();
    checks++; if (bus.rng_gen !== r) begin errors++; $display("FAIL wait rng_gen: got %b want %b", bus.rng_gen, r); end
    bus.win = 1'b1;
    press(4'h0);
    checks++; if (bus.timer_enable !== 1'b1) begin errors++; $display("FAIL play timer_enable: got %b want 1", bus.timer_enable); end
    tick();
    bus.win = 1'b0;
    checks++; if (bus.win_count !== 7'd0) begin errors++; $display("FAIL held win counted: got %0d want 0", bus.win_count); end
    cnt = 0;
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(1, 3)) begin
        l = 1'($urandom);
        r = 1'($urandom);
        bus.load_in = l;
        bus.rng_button = r;
        tick();
        checks++; if (bus.load_out !== l || bus.rng_gen !== r) begin
          errors++; $display("FAIL play mirror: got load=%b rng=%b want %b %b", bus.load_out, bus.rng_gen, l, r);
        end
      end
      bus.win = 1'b1;
      bus.timeout = (p == 4);
      tick();
      bus.win = 1'b0;
      bus.timeout = 1'b0;
      cnt++;
      checks++; if (bus.win_count !== 7'(cnt)) begin errors++; $display("FAIL win count: got %0d want %0d", bus.win_count, cnt); end
    end
    checks++; if (bus.gameover !== 1'b1 || bus.load_out !== 1'b0 || bus.timer_enable !== 1'b0 || bus.rng_gen !== 1'b1) begin
      errors++; $display("FAIL over outputs: got go=%b load=%b tmr=%b rng=%b want 1 0 0 1",
                          bus.gameover, bus.load_out, bus.timer_enable, bus.rng_gen);
    end
    bus.load_in = 1'b0;
  endtask

  task automatic test_saturate();
    int cnt;
    press(4'h0);
    checks++; if (bus.reconfig !== 1'b1 || bus.gameover !== 1'b0 || bus.login_led !== 1'b1) begin
      errors++; $display("FAIL restart reconfig: got rc=%b go=%b login=%b want 1 0 1", bus.reconfig, bus.gameover, bus.login_led);
    end
    tick();
    checks++; if (bus.win_count !== 7'd0) begin errors++; $display("FAIL restart win clear: got %0d want 0", bus.win_count); end
    press(4'h0);
    cnt = 0;
    for (int p = 0; p < 120; p++) begin
      bus.win = 1'b1;
      tick();
      bus.win = 1'b0;
      cnt = (cnt + 1 > 99) ? 99 : cnt + 1;
      checks++; if (bus.win_count !== 7'(cnt)) begin errors++; $display("FAIL saturate pulse %0d: got %0d want %0d", p, bus.win_count, cnt); end
      repeat ($urandom_range(1, 2)) tick();
    end
    bus.timeout = 1'b1;
    tick();
    bus.timeout = 1'b0;
    checks++; if (bus.gameover !== 1'b1 || bus.win_count !== 7'd99) begin
      errors++; $display("FAIL saturate over: got go=%b win=%0d want 1 99", bus.gameover, bus.win_count);
    end
  endtask

  task automatic test_wide();
    logic [47:0] bad;
    logic [2:0] l;
    do_reset();
    bad = WCODE ^ 48'h1;
    for (int i = 0; i < 6; i++) press2(bad[47-8*i -: 8]);
    tick();
    checks++; if (bus2.fail_count !== 2'd1) begin errors++; $display("FAIL wide wrong: got fail=%0d want 1", bus2.fail_count); end
    for (int i = 0; i < 6; i++) press2(WCODE[47-8*i -: 8]);
    tick();
    checks++; if (bus2.reconfig !== 1'b1 || bus2.fail_count !== 2'd0) begin
      errors++; $display("FAIL wide login: got rc=%b fail=%0d want 1 0", bus2.reconfig, bus2.fail_count);
    end
    for (int c = 0; c < 4; c++) begin
      l = 3'($urandom);
      bus2.load_in = l;
      tick();
      checks++; if (bus2.load_out !== 3'd0) begin errors++; $display("FAIL wide gate pre-play: got %b want 000", bus2.load_out); end
    end
    press2(8'h00);
    checks++; if (bus2.load_out !== l) begin errors++; $display("FAIL wide play entry: got %b want %b", bus2.load_out, l); end
    for (int c = 0; c < 8; c++) begin
      l = 3'($urandom);
      bus2.load_in = l;
      tick();
      checks++; if (bus2.load_out !== l) begin errors++; $display("FAIL wide mirror: got %b want %b", bus2.load_out, l); end
    end
    bus2.load_in = 3'b111;
    bus2.timeout = 1'b1;
    tick();
    bus2.timeout = 1'b0;
    checks++; if (bus2.load_out !== 3'd0 || bus2.gameover !== 1'b1) begin
      errors++; $display("FAIL wide over: got load=%b go=%b want 000 1", bus2.load_out, bus2.gameover);
    end
    bus2.load_in = 3'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h1234);
      tick();
    end
    repeat (50) tick();
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL mid-lockout setup: got locked=%b want 1", bus.locked); end
    rst = 1'b0;
    tick();
    checks++; if (out_vec() !== RST_VEC) begin errors++; $display("FAIL reset mid-lockout: got %h want %h", out_vec(), RST_VEC); end
    rst = 1'b1;
    login();
    press(4'h0);
    bus.load_in = 1'b1;
    repeat (3) begin bus.win = 1'b1; tick(); bus.win = 1'b0; tick(); end
    checks++; if (bus.win_count !== 7'd3) begin errors++; $display("FAIL mid-play setup: got win=%0d want 3", bus.win_count); end
    rst = 1'b0;
    tick();
    checks++; if (out_vec() !== RST_VEC) begin errors++; $display("FAIL reset mid-play: got %h want %h", out_vec(), RST_VEC); end
    rst = 1'b1;
    bus.load_in = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.pass_digit = '0;  bus.pass_enter = 1'b0;  bus.load_in = '0;
    bus.rng_button = 1'b0; bus.timeout = 1'b0;    bus.win = 1'b0;
    bus2.pass_digit = '0; bus2.pass_enter = 1'b0; bus2.load_in = '0;
    bus2.rng_button = 1'b0; bus2.timeout = 1'b0;  bus2.win = 1'b0;
    test_reset();
    test_login();
    test_random_codes();
    test_lockout();
    test_play();
    test_saturate();
    test_wide();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/access_ctrl_n.md
# access_ctrl_n

Parametrised game-access controller for the reaction-game top level. It accepts a CODE_LEN-digit passcode one digit per enter pulse and enforces a lockout after repeated failures. On successful login it sequences timer reconfiguration, game start, play and game-over. During play it gates the RNG and N_PLAYERS load channels and keeps a saturating count of rising edges on `win`.

## Interface
- CODE_LEN, 4: number of passcode digits (1..8)
- DIGIT_W, 4: bits per digit
- PASSCODE, 16'h9861: packed code, CODE_LEN*DIGIT_W bits; digit 0 (first entered) is the most-significant slice
- MAX_TRIES, 3: consecutive failed verifies that trigger lockout (≥1)
- LOCK_CYCLES, 1000: lockout duration in clk cycles (≥1)
- N_PLAYERS, 1: number of load channels
- WIN_MAX, 99: win counter saturation value
- WIN_W, 7: win_count width, must hold WIN_MAX

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- pass_digit  in  DIGIT_W  digit value, sampled when pass_enter=1
- pass_enter  in  1  single-cycle enter pulse (debounced upstream); also start/restart command
- load_in  in  N_PLAYERS  per-player load request
- rng_button  in  1  RNG control from button
- timeout  in  1  game timer expired
- win  in  1  win level from comparator
- load_out  out  N_PLAYERS  gated load_in
- rng_gen  out  1  RNG enable
- timer_enable  out  1  game timer run
- reconfig  out  1  one-cycle timer reconfigure pulse
- logout_led, login_led  out  1  session indicators
- gameover  out  1  game-over indicator
- locked  out  1  lockout active
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive failures
- win_count  out  WIN_W  saturating win counter

## Operation
- States: ENTER, VERIFY, LOCKOUT, RECONFIG, WAIT_START, PLAY, OVER.
- ENTER:
  - Each pass_enter compares pass_digit against PASSCODE slice[idx], clears `match` on mismatch, and increments idx.
  - The pass_enter at idx=CODE_LEN-1 moves to VERIFY.
  - Outputs: rng_gen=1, load_out=0, timer_enable=0.
- VERIFY (one cycle):
  - match=1: clear fail_count → RECONFIG.
  - Else fail_count+1. If the new value equals MAX_TRIES → LOCKOUT; otherwise → ENTER with idx=0, match=1.
- LOCKOUT:
  - locked=1; all pass_enter ignored.
  - Counts LOCK_CYCLES cycles, then clears fail_count and goes → ENTER.
- RECONFIG: reconfig=1 for exactly one cycle, gameover=0 → WAIT_START.
- WAIT_START:
  - win_count=0, login_led=1, logout_led=0, rng_gen=rng_button.
  - pass_enter → PLAY with timer_enable=1.
- PLAY:
  - rng_gen=rng_button, load_out=load_in.
  - Rising edge of win (win=1, prev_win=0) increments win_count, saturating at WIN_MAX.
  - timeout=1 → OVER with timer_enable=0.
- OVER:
  - gameover=1, rng_gen=1, load_out=0.
  - pass_enter → RECONFIG. Login is retained; no re-entry of the passcode.
- Logout happens only through reset.

## Timing
- All outputs are registered and change on the clk edge following the causing input.
- Reset values:
  - State ENTER, idx=0, match=1, fail_count=0, win_count=0, prev_win=0.
  - rng_gen=1, logout_led=1; all other outputs 0, including locked.
- Reset has priority over everything, in any state, including mid-lockout and mid-play.
- prev_win is updated every cycle in every state. A win held high on entry to PLAY therefore does not count.
- Latencies:
  - Last digit pulse to RECONFIG: 2 cycles.
  - Login to WAIT_START: 3 cycles.
  - Lockout end: locked deasserts exactly LOCK_CYCLES cycles after it asserts.
- Counting rules:
  - A pass_enter held high counts once per cycle.
  - A wrong digit does not abort entry; all CODE_LEN digits are always collected before verify.
- Simultaneous events:
  - timeout and a win edge in the same PLAY cycle: the win is counted and the state goes to OVER.
  - win_count at WIN_MAX plus a win edge: holds at WIN_MAX.
- Illegal state encodings recover to the reset values.

## Structure
- Shared package `access_pkg`:
  - state enum.
  - Function `digit_at(code, i)` returning the MSB-first slice.
  - Localparam rules: fail_count width, lockout counter width = $clog2(LOCK_CYCLES+1).
- Sub-module `lockout_timer`: load/count-down with a `done` pulse, parameter LOCK_CYCLES.
- FSM, digit checker and win counter live in access_ctrl_n.

## Test plan
- Defaults; enter 9,8,6,1 → reconfig pulses 2 cycles after last enter, login_led=1, logout_led=0, fail_count=0.
- Enter 9,8,6,2 three times → fail_count steps 1,2,3. locked=1 for exactly 1000 cycles, with enters ignored. Then fail_count=0 and correct entry logs in.
- PLAY with 5 win pulses, one coincident with timeout → win_count=5, state OVER, gameover=1, load_out=0.
- 120 win pulses in PLAY → win_count saturates at 99. pass_enter in OVER → reconfig pulse, then win_count=0 in WAIT_START.
- CODE_LEN=6, DIGIT_W=8, N_PLAYERS=3, PASSCODE=48'h0102030405FF → correct code logs in. load_out mirrors load_in only in PLAY.
- rst low mid-lockout and mid-PLAY → next cycle all outputs at reset values, locked=0, fail_count=0.
